call_arbiter: RTL and testbench
===============================

Name: call_arbiter

Overview:
- Shares one start/done function unit (callee: a, b in; result out; start/done handshake, e.g. the 32-bit multiply function) among N_REQ requesters.
- Sits between the requesters and the single callee instance.
- Arbitrates round-robin, latches operands, issues a one-cycle start, waits for done with a timeout guard, then returns the result to the granted requester.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- TIMEOUT, 1024, max WAIT cycles before abort (≥4)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester call request, level, held until ack
- a_in  in  N_REQ*WIDTH  operand a, slice i belongs to requester i
- b_in  in  N_REQ*WIDTH  operand b, slice i
- ack  out  N_REQ  one-cycle pulse to the served requester
- err  out  1  one-cycle pulse coincident with ack when the call timed out
- result_out  out  WIDTH  result of the last completed call, held
- busy  out  1  high in every state except IDLE
- f_start  out  1  callee start, one-cycle pulse
- f_a  out  WIDTH  latched operand a to callee
- f_b  out  WIDTH  latched operand b to callee
- f_result  in  WIDTH  callee result
- f_done  in  1  callee done (level; may stay high from the previous call)

Behaviour:
- Reset (async):
  - state=IDLE.
  - ack, err, f_start, busy = 0.
  - result_out, f_a, f_b = 0.
  - RR pointer = 0, timeout counter = 0.
  - Reset mid-call abandons the call; no ack is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Latch the grant index, f_a=a_in[g], f_b=b_in[g].
  - Go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE:
  - f_start=1 for exactly this cycle.
  - Clear the counter and go to WAIT.
- WAIT:
  - f_done is ignored in the first WAIT cycle, because a stale done from the previous call may still be high.
  - From the second WAIT cycle on, f_done=1 captures result_out<=f_result and moves to RESP.
  - The counter increments every WAIT cycle. When it reaches TIMEOUT-1 without a valid done, go to RESP with the timeout flag set; result_out is unchanged.
- RESP:
  - ack[g]=1 for one cycle; err=timeout flag.
  - Pointer <= (g+1) mod N_REQ.
  - Go to IDLE.
- Latency: req sampled in IDLE at cycle 0 → f_start at cycle 1 → done first honoured at cycle 3 → ack at cycle (done cycle +1). Best case is ack at cycle 4.
- Throughput: at least one IDLE cycle between calls.
- Requesters must drop req in the cycle after ack, or a new call starts.
- Operands are sampled only in IDLE. Changes to a_in/b_in during a call have no effect.
- If req[g] drops mid-call, the call still completes and ack[g] still pulses.
- Simultaneous requests: only one is granted. Others wait, with no starvation; the worst-case wait is N_REQ-1 calls.
- f_a/f_b are held stable from ISSUE through RESP.
- Outputs are registered; nothing combinational from req to the callee.

Test Plan:
- Reset pulse (1 cycle); req[0] with a=1, b=2 against the multiply callee → f_start pulses once, ack[0] pulses once, result_out=2, err=0, busy returns to 0.
- req[1] with a=7, b=4 → ack[1], result_out=28. The stale f_done from the prior call is not taken as completion; f_start occurs exactly once.
- req[0], req[2], req[3] asserted in the same cycle with operands (2,3), (5,5), (6,7); each drops req after its ack:
  - acks arrive in order 0, 2, 3;
  - results 6, 25, 42;
  - at most 3 f_start pulses.
- All four req held continuously for 8 calls → grant sequence 0, 1, 2, 3, 0, 1, 2, 3, with no requester served twice before the others are served.
- Stub callee never asserts done, TIMEOUT=16 → ack[g] and err pulse together 16 WAIT cycles after f_start+1. result_out keeps its previous value, and the arbiter serves the next req normally.
- Assert reset in the middle of WAIT → outputs go to 0 immediately (async), no ack is issued. After release, a new call 3×3 returns 9.

Source files
------------

// File: rtl/call_arbiter.sv
// call_arbiter
//   Shares a single start/done function unit (the callee) among N_REQ
//   requesters. Grants round-robin, latches the granted operands, pulses
//   f_start once, waits for f_done under a timeout guard, then acks the
//   granted requester (with err if the call timed out).
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   req[N_REQ]          level requests, held until ack
//   a_in, b_in          packed operands, slice i belongs to requester i
//   ack[N_REQ]          one-cycle pulse to the served requester
//   err                 one-cycle pulse with ack when the call timed out
//   result_out          result of the last completed call, held
//   busy                high whenever the FSM is not idle
//   f_start, f_a, f_b   callee start pulse and latched operands
//   f_result, f_done    callee result and (level) done
//
// state  | meaning
// IDLE   | waiting for any req; grants and latches operands on exit
// ISSUE  | f_start pulse, timeout counter cleared
// WAIT   | waiting for a fresh f_done; first cycle ignores stale done
// RESP   | ack to the granted requester, pointer advances
module call_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       ack,
  output logic                   err,
  output logic [WIDTH-1:0]       result_out,
  output logic                   busy,
  output logic                   f_start,
  output logic [WIDTH-1:0]       f_a,
  output logic [WIDTH-1:0]       f_b,
  input  logic [WIDTH-1:0]       f_result,
  input  logic                   f_done
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         r_state, w_next;
  logic [IW-1:0]  r_grant, r_ptr, w_pick;
  logic           w_any;
  logic [CW-1:0]  r_cnt;
  logic           r_tmo;
  logic           w_done_ok, w_expire;
  logic [IW:0]    w_idx;
  logic [WIDTH-1:0] w_a [N_REQ];
  logic [WIDTH-1:0] w_b [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign w_a[k] = a_in[k*WIDTH +: WIDTH];
    assign w_b[k] = b_in[k*WIDTH +: WIDTH];
  end

  // Round-robin pick: scan offsets from the highest down so the smallest
  // offset from the pointer is the last (winning) assignment.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_idx >= (IW+1)'(N_REQ)) w_idx = w_idx - (IW+1)'(N_REQ);
      if (req[w_idx[IW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[IW-1:0];
      end
    end
  end

  // r_cnt == 0 only in the first WAIT cycle, where done may be stale.
  assign w_done_ok = (r_cnt != '0) && f_done;
  assign w_expire  = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    ack     = '0;
    err     = 1'b0;
    busy    = (r_state != S_IDLE);
    f_start = 1'b0;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: begin
        f_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT:  if (w_done_ok || w_expire) w_next = S_RESP;
      S_RESP: begin
        ack[r_grant] = 1'b1;
        err          = r_tmo;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant    <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_tmo      <= 1'b0;
      f_a        <= '0;
      f_b        <= '0;
      result_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            f_a     <= w_a[w_pick];
            f_b     <= w_b[w_pick];
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
          r_tmo <= 1'b0;
        end
        S_WAIT: begin
          if (w_done_ok)     result_out <= f_result;
          else if (w_expire) r_tmo      <= 1'b1;
          else               r_cnt      <= r_cnt + 1'b1;
        end
        S_RESP: begin
          r_ptr <= (r_grant == IW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_call_arbiter.sv
// tb_call_arbiter
//   Self-checking bench for call_arbiter. A behavioural multiply callee with
//   programmable latency (or a never-done mode) sits on the f_* port; the
//   expected grant order, result, error flag and latency come from a small
//   pending-set / pointer model kept here.
module tb_call_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   ack;
  logic           err, busy, f_start;
  logic [W-1:0]   result_out, f_a, f_b;
  logic [W-1:0]   f_result = '0;
  logic           f_done = 1'b0;

  int           c_lat = 0;
  bit           c_never = 1'b0;
  logic         c_pend = 1'b0;
  int           c_dly = 0;
  logic [W-1:0] c_a = '0, c_b = '0;

  int           n_checks = 0;
  int           n_err = 0;
  int           m_ptr = 0;
  logic [W-1:0] m_res = '0;

  call_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .err(err), .result_out(result_out), .busy(busy),
    .f_start(f_start), .f_a(f_a), .f_b(f_b),
    .f_result(f_result), .f_done(f_done)
  );

  always #5 clk = ~clk;

  // Callee: done stays at its old level for one cycle after start (stale),
  // drops, then rises c_lat cycles later with the product.
  always @(posedge clk) begin
    if (f_start) begin
      c_pend <= 1'b1;
      c_dly  <= c_lat;
      c_a    <= f_a;
      c_b    <= f_b;
    end else if (c_pend) begin
      if (c_dly == 0) begin
        f_done <= !c_never;
        if (!c_never) f_result <= c_a * c_b;
        c_pend <= 1'b0;
      end else begin
        f_done <= 1'b0;
        c_dly  <= c_dly - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] set_slice(input logic [N*W-1:0] v, input int g,
                                               input logic [W-1:0] x);
    logic [N*W-1:0] m, d;
    m = '0; m[W-1:0] = '1;
    d = '0; d[W-1:0] = x;
    return (v & ~(m << (g*W))) | (d << (g*W));
  endfunction

  function automatic logic [W-1:0] get_slice(input logic [N*W-1:0] v, input int g);
    return W'(v >> (g*W));
  endfunction

  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int i = 0; i < N; i++)
      if (((p >> ((ptr + i) % N)) & N'(1)) != '0) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic wait_ack(input int g, input bit drop_mid, output int idx, output logic e,
                          output int cyc, output int starts);
    bit got;
    got = 1'b0; idx = -1; e = 1'b0; cyc = 0; starts = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (f_start) starts++;
      if (drop_mid && cyc == 2) req = req & ~(N'(1) << g);
      // operands change mid-call; the latched values must not follow
      if (cyc == 3) begin
        a_in = set_slice(a_in, g, $urandom);
        b_in = set_slice(b_in, g, $urandom);
      end
      if (ack != '0) begin
        got = 1'b1;
        e   = err;
        for (int i = 0; i < N; i++) if (ack == (N'(1) << i)) idx = i;
        chk("ack_onehot", $countones(ack), 1);
      end
    end
    chk("ack_arrived", got, 1);
  endtask

  task automatic run_batch(input logic [N-1:0] mask, input bit hold, input int ncalls,
                           input int lat, input bit nev, input bit drop_mid);
    logic [N-1:0] pend;
    int g, idx, cyc, starts, exp_lat;
    logic e;
    logic [W-1:0] ea, eb, er;
    pend    = mask;
    c_lat   = lat;
    c_never = nev;
    req     = req | mask;
    for (int k = 0; k < ncalls; k++) begin
      g  = pick(pend, m_ptr);
      ea = get_slice(a_in, g);
      eb = get_slice(b_in, g);
      er = nev ? m_res : ea * eb;
      exp_lat = (nev ? TO + 2 : 4 + lat) + (k == 0 ? 0 : 1);
      wait_ack(g, drop_mid, idx, e, cyc, starts);
      chk("grant", idx, g);
      chk("err", e, nev);
      chk("result_out", result_out, er);
      chk("f_a", f_a, ea);
      chk("f_b", f_b, eb);
      chk("latency", cyc, exp_lat);
      chk("f_start_count", starts, 1);
      if (!hold || drop_mid) begin
        pend = pend & ~(N'(1) << g);
        req  = req & ~(N'(1) << g);
      end
      m_ptr = (g + 1) % N;
      m_res = er;
    end
    req = req & ~mask;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ack", ack, 0);
  endtask

  initial begin
    logic [N-1:0] mask;
    bit hold;
    int seen;

    // reset state
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", f_start, 0);
    chk("rst_result", result_out, 0);
    chk("rst_fa", f_a, 0);
    chk("rst_fb", f_b, 0);
    reset = 1'b0;

    // single call 1*2, fastest callee
    a_in = set_slice(a_in, 0, 1); b_in = set_slice(b_in, 0, 2);
    run_batch(4'b0001, 0, 1, 0, 0, 0);

    // 7*4 with stale done still high from the previous call
    a_in = set_slice(a_in, 1, 7); b_in = set_slice(b_in, 1, 4);
    run_batch(4'b0010, 0, 1, 2, 0, 0);

    // three simultaneous requesters
    a_in = set_slice(a_in, 0, 2); b_in = set_slice(b_in, 0, 3);
    a_in = set_slice(a_in, 2, 5); b_in = set_slice(b_in, 2, 5);
    a_in = set_slice(a_in, 3, 6); b_in = set_slice(b_in, 3, 7);
    run_batch(4'b1101, 0, 3, 1, 0, 0);

    // all four held for 8 calls: strict rotation
    for (int s = 0; s < N; s++) begin
      a_in = set_slice(a_in, s, $urandom); b_in = set_slice(b_in, s, $urandom);
    end
    run_batch(4'b1111, 1, 8, 0, 0, 0);

    // callee never completes: timeout, then a normal call
    run_batch(4'b0100, 0, 1, 0, 1, 0);
    a_in = set_slice(a_in, 0, 11); b_in = set_slice(b_in, 0, 13);
    run_batch(4'b0001, 0, 1, 1, 0, 0);

    // requester withdraws mid-call; ack still issued
    run_batch(4'b1000, 0, 1, 3, 0, 1);

    // randomized batches
    for (int r = 0; r < 6; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      hold = 1'($urandom_range(0, 1));
      for (int s = 0; s < N; s++) begin
        a_in = set_slice(a_in, s, $urandom); b_in = set_slice(b_in, s, $urandom);
      end
      run_batch(mask, hold, hold ? $urandom_range(1, 6) : $countones(mask),
                $urandom_range(0, 3), 0, 0);
    end

    // reset in the middle of WAIT
    c_never = 1'b1;
    req = 4'b0100;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_start", f_start, 0);
    chk("mid_rst_fa", f_a, 0);
    chk("mid_rst_fb", f_b, 0);
    chk("mid_rst_result", result_out, 0);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    m_res = '0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack != '0) seen++;
    end
    chk("no_ack_after_reset", seen, 0);
    a_in = set_slice(a_in, 1, 3); b_in = set_slice(b_in, 1, 3);
    run_batch(4'b0010, 0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
